pio_edge_dispatcher: RTL
========================

Name: pio_edge_dispatcher

Overview:
- Avalon-MM master that services the 32-bit edge-capturing input PIO (`sys_pio_in` register map: 0 = data, 2 = irq_mask, 3 = edge_capture; any write to 3 clears all capture bits).
- Out of reset it programs irq_mask. On PIO irq it reads and clears edge_capture, then snapshots the input level.
- It then serialises the captured edges as one event per bit, lowest index first, on a valid/ready stream to the ECU event logic.
- It removes the need for CPU polling of the PIO.

Parameters:
- DATA_W, 32, PIO width; must be 32 to match the PIO.
- IDX_W, 5, event index width, equal to clog2(DATA_W).
- IRQ_MASK_INIT, 32'hFFFF_FFFF, value written to PIO irq_mask after reset.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- irq_in  in  1  PIO irq output
- avm_address  out  2  PIO register address
- avm_chipselect  out  1  PIO chipselect
- avm_write_n  out  1  PIO write strobe, active low
- avm_writedata  out  32  PIO write data
- avm_readdata  in  32  PIO readdata; registered in the PIO, fixed read latency 1, no waitrequest
- cfg_mask_wr  in  1  single-cycle request to reprogram irq_mask
- cfg_mask  in  32  new mask value, sampled when cfg_mask_wr=1
- evt_valid  out  1  event available
- evt_ready  in  1  consumer accepts event
- evt_index  out  IDX_W  bit number that saw a rising edge
- evt_level  out  1  input level of that bit at snapshot time
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, active-high) values:
  - avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0.
  - evt_valid=0, evt_index=0, evt_level=0, busy=1.
  - Internal cap_reg=0, lvl_reg=0, mask_pend=0. State=INIT_MASK.
- All Avalon outputs are registered. Each access is exactly one cycle of chipselect.
- States and transitions:
  - INIT_MASK: drive cs=1, write_n=0, addr=2, wdata=IRQ_MASK_INIT for one cycle -> IDLE.
  - IDLE:
    - if mask_pend -> MASK_WR;
    - else if irq_in -> RD_CAP;
    - else stay.
    - cfg_mask_wr in any state latches cfg_mask and sets mask_pend; a later request overwrites the earlier one.
  - MASK_WR: one write cycle, addr=2, wdata=latched mask; clear mask_pend -> IDLE.
  - RD_CAP: cs=1, write_n=1, addr=3 for one cycle -> WAIT_CAP.
  - WAIT_CAP: latch avm_readdata into cap_reg.
    - if readdata==0 (spurious irq) -> IDLE, no clear written, no events;
    - else -> CLR_CAP.
  - CLR_CAP: write addr=3, wdata=all ones -> RD_LVL.
  - RD_LVL: read addr=0 -> WAIT_LVL.
  - WAIT_LVL: latch readdata into lvl_reg -> EMIT.
  - EMIT:
    - evt_index = lowest set bit of cap_reg; evt_level = lvl_reg[evt_index]; evt_valid=1.
    - Outputs are held stable while evt_ready=0.
    - On valid&&ready the bit is cleared in cap_reg. The next event is presented on the following cycle, with no bubble and evt_valid kept high.
    - When the last bit is accepted -> IDLE, with evt_valid low the next cycle.
- Latency:
  - irq_in seen high in IDLE at cycle N gives the RD_CAP access at N+1 and cap_reg latched at N+2.
  - First evt_valid at N+6 with no mask write pending.
- Re-arm: returning to IDLE with irq_in still high starts a new RD_CAP on the next cycle. A pending mask write takes priority.
- Accepted loss window: an edge captured by the PIO between the RD_CAP sample and the CLR_CAP write is cleared unreported. This is at most 2 cycles and is a documented limitation, not a bug.
- irq_in is ignored outside IDLE.
- Mid-operation reset: the state machine returns to INIT_MASK and undelivered events are discarded. The PIO itself is reset by its own reset.
- busy=0 only in IDLE.

Decomposition:
- Package pio_dispatch_pkg holds:
  - state enum (INIT_MASK, IDLE, MASK_WR, RD_CAP, WAIT_CAP, CLR_CAP, RD_LVL, WAIT_LVL, EMIT);
  - address constants PIO_ADDR_DATA=2'd0, PIO_ADDR_MASK=2'd2, PIO_ADDR_EDGE=2'd3.
- Sub-module lsb_priority_enc: combinational, DATA_W-in, IDX_W index out plus an any-bit flag. It is used in EMIT.

Test Plan:
- Reset release -> exactly one write: addr=2, wdata=32'hFFFF_FFFF, at cycle 1 after reset falls; then busy=0.
- Rising edges on in_port bits 3 and 17, with bit 3 returning low before RD_LVL and evt_ready=1 -> two events:
  - (idx 3, level 0) then (idx 17, level 1), on consecutive cycles;
  - one write to addr 3 is observed;
  - PIO irq drops.
- Same stimulus with evt_ready held 0 for 10 cycles -> evt_valid=1 and idx=3 stable throughout; no second event until the handshake.
- cfg_mask_wr with 32'h0000_00FF during EMIT -> the mask write occurs only after return to IDLE, before any new RD_CAP; an edge on bit 9 then produces no irq and no event.
- Forced spurious irq_in with edge_capture=0 -> RD_CAP, WAIT_CAP, then IDLE; no addr-3 write; no events.
- reset asserted in EMIT with 3 bits pending -> evt_valid=0 immediately; after release, INIT_MASK write repeats and no stale events appear.

Source files
------------

// File: rtl/pio_dispatch_pkg.sv
// Shared types and PIO register addresses for the edge-capture PIO dispatcher.
package pio_dispatch_pkg;

    typedef enum logic [3:0] {
        INIT_MASK,
        IDLE,
        MASK_WR,
        RD_CAP,
        WAIT_CAP,
        CLR_CAP,
        RD_LVL,
        WAIT_LVL,
        EMIT
    } state_e;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

endpackage

// File: rtl/lsb_priority_enc.sv
// Combinational lowest-set-bit encoder: index of the least significant 1 plus an any-bit flag.
module lsb_priority_enc #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 5
) (
    input  logic [DATA_W-1:0] i_vec,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_any
);

    // Scanning downward lets the lowest set bit win the final assignment.
    always_comb begin
        o_idx = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

    assign o_any = |i_vec;

endmodule

// File: rtl/pio_edge_dispatcher.sv
// Avalon-MM master that drains the edge-capturing PIO on irq and streams one event per captured bit.
module pio_edge_dispatcher
    import pio_dispatch_pkg::*;
#(
    parameter int unsigned      DATA_W        = 32,
    parameter int unsigned      IDX_W         = 5,
    parameter logic [DATA_W-1:0] IRQ_MASK_INIT = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              irq_in,
    output logic [1:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              cfg_mask_wr,
    input  logic [DATA_W-1:0] cfg_mask,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [IDX_W-1:0]  evt_index,
    output logic              evt_level,
    output logic              busy
);

    state_e            r_state, w_state_next;
    logic              r_cs, w_cs;
    logic              r_wr_n, w_wr_n;
    logic [1:0]        r_addr, w_addr;
    logic [DATA_W-1:0] r_wdata, w_wdata;
    logic [DATA_W-1:0] r_cap, w_cap_next;
    logic [DATA_W-1:0] r_lvl;
    logic [DATA_W-1:0] r_mask;
    logic              r_mask_pend;
    logic [IDX_W-1:0]  w_idx;
    logic              w_any;
    logic [DATA_W-1:0] w_onehot;
    logic [DATA_W-1:0] w_mask_wdata;

    lsb_priority_enc #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_enc (
        .i_vec (r_cap),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_onehot     = {{(DATA_W-1){1'b0}}, 1'b1} << w_idx;
    // A request arriving in the same cycle as the IDLE decision must not be lost.
    assign w_mask_wdata = cfg_mask_wr ? cfg_mask : r_mask;

    // Avalon outputs are registered from the decision, so each access is visible in the next state.
    always_comb begin
        w_state_next = r_state;
        w_cs         = 1'b0;
        w_wr_n       = 1'b1;
        w_addr       = '0;
        w_wdata      = '0;
        w_cap_next   = r_cap;
        case (r_state)
            INIT_MASK: begin
                w_state_next = IDLE;
                w_cs         = 1'b1;
                w_wr_n       = 1'b0;
                w_addr       = PIO_ADDR_MASK;
                w_wdata      = IRQ_MASK_INIT;
            end
            IDLE: begin
                if (r_mask_pend) begin
                    w_state_next = MASK_WR;
                    w_cs         = 1'b1;
                    w_wr_n       = 1'b0;
                    w_addr       = PIO_ADDR_MASK;
                    w_wdata      = w_mask_wdata;
                end else if (irq_in) begin
                    w_state_next = RD_CAP;
                    w_cs         = 1'b1;
                    w_addr       = PIO_ADDR_EDGE;
                end
            end
            MASK_WR:  w_state_next = IDLE;
            RD_CAP:   w_state_next = WAIT_CAP;
            WAIT_CAP: begin
                w_cap_next = avm_readdata;
                if (avm_readdata == '0) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = CLR_CAP;
                    w_cs         = 1'b1;
                    w_wr_n       = 1'b0;
                    w_addr       = PIO_ADDR_EDGE;
                    w_wdata      = '1;
                end
            end
            CLR_CAP: begin
                w_state_next = RD_LVL;
                w_cs         = 1'b1;
                w_addr       = PIO_ADDR_DATA;
            end
            RD_LVL:   w_state_next = WAIT_LVL;
            WAIT_LVL: w_state_next = EMIT;
            EMIT: begin
                if (evt_ready && w_any) begin
                    w_cap_next = r_cap & ~w_onehot;
                    if ((r_cap & ~w_onehot) == '0) begin
                        w_state_next = IDLE;
                    end
                end
            end
            default:  w_state_next = INIT_MASK;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= INIT_MASK;
            r_cs        <= 1'b0;
            r_wr_n      <= 1'b1;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cap       <= '0;
            r_lvl       <= '0;
            r_mask      <= '0;
            r_mask_pend <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cs    <= w_cs;
            r_wr_n  <= w_wr_n;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_cap   <= w_cap_next;
            if (r_state == WAIT_LVL) begin
                r_lvl <= avm_readdata;
            end
            if (cfg_mask_wr) begin
                r_mask      <= cfg_mask;
                r_mask_pend <= 1'b1;
            end else if (r_state == MASK_WR) begin
                r_mask_pend <= 1'b0;
            end
        end
    end

    assign avm_chipselect = r_cs;
    assign avm_write_n    = r_wr_n;
    assign avm_address    = r_addr;
    assign avm_writedata  = r_wdata;

    assign evt_valid = (r_state == EMIT);
    assign evt_index = w_idx;
    assign evt_level = r_lvl[w_idx];
    assign busy      = (r_state != IDLE);

endmodule
